// File: rtl/switch_debouncer_if.sv
// Switch bank bundle: raw levels in, debounced vector and status out.
// Ports: sw_raw (raw levels), s (committed), s_changed (pulse), s_settling.
interface switch_debouncer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] s;
  logic             s_changed;
  logic             s_settling;

  modport master (
    output sw_raw,
    input  s,
    input  s_changed,
    input  s_settling
  );

  modport slave (
    input  sw_raw,
    output s,
    output s_changed,
    output s_settling
  );

endinterface

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus whole-vector debounce FSM for the DIP bank.
// Ports: clk, reset (sync, active-low), bus (slave: sw_raw -> s/s_changed/s_settling).
module switch_debouncer #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 240000
) (
  input  logic            clk,
  input  logic            reset,
  switch_debouncer_if.slave bus
);

  localparam int CW =
    (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_LAST =
    CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } state_e;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] cand_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_d;
  logic             chg_q;
  logic             chg_d;

  // Synchronizer: only sync2_q is seen by the FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.sw_raw;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= STABLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      chg_q   <= chg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    chg_d   = 1'b0;

    unique case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (sync2_q != s_q) begin
          cand_d  = sync2_q;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sync2_q == s_q) begin
          // bounced back to the committed value
          cnt_d   = '0;
          state_d = STABLE;
        end else if (sync2_q != cand_q) begin
          // any bit moving restarts the whole vector
          cand_d = sync2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          s_d     = cand_q;
          chg_d   = 1'b1;
          cnt_d   = '0;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.s          = s_q;
  assign bus.s_changed  = chg_q;
  assign bus.s_settling = (state_q == SETTLE);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_CYCLES=4.
// Table of per-edge vectors plus hand sequences for bounce and mid-settle reset.
module tb_switch_debouncer;

  logic clk;
  logic reset;

  switch_debouncer_if #(.WIDTH(4)) bus ();

  switch_debouncer #(
    .WIDTH(4),
    .STABLE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] sw;
    logic [3:0] s;
    logic       chg;
    logic       set;
    string      tag;
  } vec_t;

  vec_t vq[$];
  int checks;
  int errors;

  function automatic void add(
    input logic rst, input logic [3:0] sw,
    input logic [3:0] s, input logic chg,
    input logic set, input string tag);
    vec_t v;
    v.rst = rst; v.sw = sw; v.s = s;
    v.chg = chg; v.set = set; v.tag = tag;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] sw);
    reset      = r;
    bus.sw_raw = sw;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [3:0] s,
                         input logic c, input logic st);
    chk({nm, ".s"}, bus.s, s);
    chk({nm, ".chg"}, {3'b0, bus.s_changed}, {3'b0, c});
    chk({nm, ".set"}, {3'b0, bus.s_settling}, {3'b0, st});
  endtask

  int pulses;
  int pulse_at;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.sw_raw = 4'b0000;

    // 1: reset held with switches set, then commit at edge 6
    for (int i = 0; i < 3; i++)
      add(0, 4'b1010, 4'b0000, 0, 0, "rst_hold");
    add(1, 4'b1010, 4'b0000, 0, 0, "t1_e0");
    add(1, 4'b1010, 4'b0000, 0, 0, "t1_e1");
    add(1, 4'b1010, 4'b0000, 0, 1, "t1_e2");
    add(1, 4'b1010, 4'b0000, 0, 1, "t1_e3");
    add(1, 4'b1010, 4'b0000, 0, 1, "t1_e4");
    add(1, 4'b1010, 4'b0000, 0, 1, "t1_e5");
    add(1, 4'b1010, 4'b1010, 1, 0, "t1_e6");
    add(1, 4'b1010, 4'b1010, 0, 0, "t1_e7");
    // 2: clean change 0000 -> 0110
    add(0, 4'b0000, 4'b0000, 0, 0, "t2_rst");
    add(1, 4'b0000, 4'b0000, 0, 0, "t2_idle");
    add(1, 4'b0000, 4'b0000, 0, 0, "t2_idle");
    add(1, 4'b0110, 4'b0000, 0, 0, "t2_e0");
    add(1, 4'b0110, 4'b0000, 0, 0, "t2_e1");
    add(1, 4'b0110, 4'b0000, 0, 1, "t2_e2");
    add(1, 4'b0110, 4'b0000, 0, 1, "t2_e3");
    add(1, 4'b0110, 4'b0000, 0, 1, "t2_e4");
    add(1, 4'b0110, 4'b0000, 0, 1, "t2_e5");
    add(1, 4'b0110, 4'b0110, 1, 0, "t2_e6");
    add(1, 4'b0110, 4'b0110, 0, 0, "t2_e7");
    // 4: one-cycle glitch
    add(0, 4'b0000, 4'b0000, 0, 0, "t4_rst");
    add(1, 4'b0000, 4'b0000, 0, 0, "t4_idle");
    add(1, 4'b1000, 4'b0000, 0, 0, "t4_e0");
    add(1, 4'b0000, 4'b0000, 0, 0, "t4_e1");
    add(1, 4'b0000, 4'b0000, 0, 1, "t4_e2");
    add(1, 4'b0000, 4'b0000, 0, 0, "t4_e3");
    for (int i = 4; i < 9; i++)
      add(1, 4'b0000, 4'b0000, 0, 0, "t4_tail");
    // 6: staggered change, restart at edge 4
    add(1, 4'b1000, 4'b0000, 0, 0, "t6_e0");
    add(1, 4'b1000, 4'b0000, 0, 0, "t6_e1");
    add(1, 4'b1010, 4'b0000, 0, 1, "t6_e2");
    add(1, 4'b1010, 4'b0000, 0, 1, "t6_e3");
    add(1, 4'b1010, 4'b0000, 0, 1, "t6_e4");
    add(1, 4'b1010, 4'b0000, 0, 1, "t6_e5");
    add(1, 4'b1010, 4'b0000, 0, 1, "t6_e6");
    add(1, 4'b1010, 4'b0000, 0, 1, "t6_e7");
    add(1, 4'b1010, 4'b1010, 1, 0, "t6_e8");
    add(1, 4'b1010, 4'b1010, 0, 0, "t6_e9");

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].sw);
      chk_all(vq[i].tag, vq[i].s, vq[i].chg, vq[i].set);
    end

    // 3: bounce on bit0, then hold 1
    step(0, 4'b0000);
    step(1, 4'b0000);
    step(1, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      step(1, (i % 2 == 0) ? 4'b0001 : 4'b0000);
      chk_all("t3_bounce", 4'b0000, 0, bus.s_settling);
    end
    pulses = 0;
    pulse_at = -1;
    for (int n = 0; n < 14; n++) begin
      step(1, 4'b0001);
      if (bus.s_changed) begin
        pulses++;
        if (pulse_at < 0) pulse_at = n;
      end
      if (n < 6) chk("t3_hold_s", bus.s, 4'b0000);
      else chk("t3_final_s", bus.s, 4'b0001);
    end
    chk("t3_pulse_edge", 4'(pulse_at), 4'd6);
    chk("t3_pulses", 4'(pulses), 4'd1);

    // 5: reset mid-settle, then recapture and commit
    step(0, 4'b0000);
    step(1, 4'b0000);
    step(1, 4'b1111);
    step(1, 4'b1111);
    step(1, 4'b1111);
    step(1, 4'b1111);
    chk_all("t5_e3", 4'b0000, 0, 1);
    step(0, 4'b1111);
    chk_all("t5_e4_rst", 4'b0000, 0, 0);
    pulses = 0;
    pulse_at = -1;
    for (int n = 0; n < 12; n++) begin
      step(1, 4'b1111);
      if (bus.s_changed) begin
        pulses++;
        if (pulse_at < 0) pulse_at = n;
      end
    end
    chk("t5_pulse_edge", 4'(pulse_at), 4'd6);
    chk("t5_pulses", 4'(pulses), 4'd1);
    chk("t5_final_s", bus.s, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
